// File: rtl/dram_model.sv
// dram_model: backing-memory responder for the data-cache controller.
//
// Services one mem_req/mem_ready transaction at a time. The request is
// captured on the first edge where mem_req is high in IDLE. mem_ready rises
// 'latency' edges later, and it stays high until the controller drops mem_req.
//
// Handshake: mem_req is a level. The controller holds it from issue until it
// has seen mem_ready, then drops it. If mem_req drops before mem_ready, the
// transaction is aborted. mem_ready falls on the first edge after mem_req
// drops in RESPOND. No new request is taken on that edge.
//
// Parameters:
//   data     - word width in bits
//   depth    - number of words (power of two, >= 2)
//   latency  - edges from capture to mem_ready rise (>= 1)
//   def_word - value read back from a word that has never been written
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-low reset
//   mem_req         in   request level from the cache controller
//   mem_we          in   1 = store, 0 = line-fill read
//   mem_address     in   byte address; word index = mem_address[aw+1:2]
//   write_data_int  in   store data
//   mem_ready       out  response valid / write committed
//   dram_data_input out  read data (or the committed store data)
//   xact_count      out  completed transactions, wraps at 16 bits
module dram_model #(
  parameter int              data     = 32,
  parameter int              depth    = 1024,
  parameter int              latency  = 4,
  parameter logic [data-1:0] def_word = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [31:0]     mem_address,
  input  logic [data-1:0] write_data_int,
  output logic            mem_ready,
  output logic [data-1:0] dram_data_input,
  output logic [15:0]     xact_count
);

  localparam int aw = $clog2(depth);
  localparam int cw = (latency > 1) ? $clog2(latency) : 1;
  localparam logic [cw-1:0] cnt_load = cw'(latency - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state, state_next;

  logic [cw-1:0]   cnt;
  logic [aw-1:0]   idx_q;
  logic            we_q;
  logic [data-1:0] wd_q;
  logic [depth-1:0] written;
  logic [data-1:0] mem [depth];

  logic [aw-1:0]   idx_in;
  logic            commit;
  logic            unused_addr_bits;

  // Byte offset and the bits above the index are ignored, so out-of-range
  // addresses alias modulo depth.
  assign idx_in           = mem_address[aw+1:2];
  assign unused_addr_bits = ^{mem_address[31:aw+2], mem_address[1:0]};

  // Next-state logic. commit marks the edge that completes a transaction.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) state_next = BUSY;
      end
      BUSY: begin
        if (!mem_req) begin
          state_next = IDLE;
        end else if (cnt == '0) begin
          state_next = RESPOND;
          commit     = 1'b1;
        end
      end
      RESPOND: begin
        if (!mem_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      idx_q           <= '0;
      we_q            <= 1'b0;
      wd_q            <= '0;
      written         <= '0;
      mem_ready       <= 1'b0;
      dram_data_input <= '0;
      xact_count      <= '0;
    end else begin
      state <= state_next;

      if (state == IDLE && mem_req) begin
        idx_q <= idx_in;
        we_q  <= mem_we;
        wd_q  <= write_data_int;
        cnt   <= cnt_load;
      end

      if (state == BUSY && mem_req && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (commit) begin
        mem_ready  <= 1'b1;
        xact_count <= xact_count + 16'd1;
        if (we_q) begin
          written[idx_q]  <= 1'b1;
          dram_data_input <= wd_q;
        end else begin
          dram_data_input <= written[idx_q] ? mem[idx_q] : def_word;
        end
      end

      if (state == RESPOND && !mem_req) begin
        mem_ready <= 1'b0;
      end
    end
  end

  // The data array is not reset. The written bits decide whether its
  // contents are valid.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      mem[idx_q] <= wd_q;
    end
  end

endmodule

// File: tb/tb_dram_model.sv
// Directed bench for dram_model. The main instance uses the default
// parameters (latency 4, depth 1024, def_word 0). A second instance uses
// latency 1, depth 16 and a non-zero def_word.
module tb_dram_model;

  logic        clk;
  logic        rst;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] write_data_int;
  logic        mem_ready;
  logic [31:0] dram_data_input;
  logic [15:0] xact_count;

  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wd1;
  logic        ready1;
  logic [31:0] data1;
  logic [15:0] cnt1;

  int total = 0;
  int bad   = 0;

  dram_model dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_address(mem_address), .write_data_int(write_data_int),
    .mem_ready(mem_ready), .dram_data_input(dram_data_input),
    .xact_count(xact_count)
  );

  dram_model #(.data(32), .depth(16), .latency(1), .def_word(32'h0BAD0BAD)) dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_we(we1),
    .mem_address(addr1), .write_data_int(wd1),
    .mem_ready(ready1), .dram_data_input(data1),
    .xact_count(cnt1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one full transaction on the main instance. After capture, the
  // address, data and we inputs are scrambled to show they are not
  // re-sampled. The task checks latency, data, count and the mem_ready fall.
  task automatic do_xact(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_d,
                         input logic [15:0] exp_cnt);
    int n;
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_address = addr; write_data_int = wd;
    @(posedge clk);
    @(negedge clk);
    mem_we = 1'($urandom_range(0, 1));
    mem_address = $urandom;
    write_data_int = $urandom;
    n = 0;
    while (!mem_ready && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({name, " latency"}, n, 4);
    check({name, " data"}, dram_data_input, exp_d);
    check({name, " count"}, {16'd0, xact_count}, {16'd0, exp_cnt});
    mem_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, " ready_fall"}, {31'd0, mem_ready}, 32'd0);
  endtask

  // Runs one transaction on the latency-1 instance. mem_ready must still be
  // low at the negedge right after capture and high one edge later.
  task automatic lat1_xact(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_d,
                           input logic [15:0] exp_cnt);
    @(negedge clk);
    req1 = 1'b1; we1 = we; addr1 = addr; wd1 = wd;
    @(posedge clk);
    @(negedge clk);
    check({name, " ready_early"}, {31'd0, ready1}, 32'd0);
    addr1 = $urandom; wd1 = $urandom;
    @(posedge clk);
    @(negedge clk);
    check({name, " ready"}, {31'd0, ready1}, 32'd1);
    check({name, " data"}, data1, exp_d);
    check({name, " count"}, {16'd0, cnt1}, {16'd0, exp_cnt});
    req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, " ready_fall"}, {31'd0, ready1}, 32'd0);
  endtask

  initial begin : main
    logic        flag;
    logic [31:0] held;

    vecs[0] = '{"rd_0x100_unwritten", 1'b0, 32'h0000_0100, 32'h0,         32'h0,         16'd1};
    vecs[1] = '{"wr_0x40",            1'b1, 32'h0000_0040, 32'hDEADBEEF,  32'hDEADBEEF,  16'd2};
    vecs[2] = '{"rd_0x40",            1'b0, 32'h0000_0040, 32'h0,         32'hDEADBEEF,  16'd3};
    vecs[3] = '{"rd_0x40_alias",      1'b0, 32'h0000_1040, 32'h0,         32'hDEADBEEF,  16'd4};
    vecs[4] = '{"wr_0x2003_word0",    1'b1, 32'h0000_2003, 32'h0BADF00D,  32'h0BADF00D,  16'd5};
    vecs[5] = '{"rd_0x0",             1'b0, 32'h0000_0000, 32'h0,         32'h0BADF00D,  16'd6};
    vecs[6] = '{"rd_top_unwritten",   1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         16'd7};
    vecs[7] = '{"wr_0xFFC",           1'b1, 32'h0000_0FFC, 32'hCAFEF00D,  32'hCAFEF00D,  16'd8};
    vecs[8] = '{"rd_top_alias",       1'b0, 32'hFFFF_FFFE, 32'h0,         32'hCAFEF00D,  16'd9};

    rst = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_address = '0; write_data_int = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wd1 = '0;
    repeat (2) @(negedge clk);
    check("reset ready", {31'd0, mem_ready}, 32'd0);
    check("reset data", dram_data_input, 32'd0);
    check("reset count", {16'd0, xact_count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_xact(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp_d, vecs[i].exp_cnt);
    end

    // Abort: a write to 0x80 whose mem_req drops two edges after capture.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_address = 32'h80; write_data_int = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready) flag = 1'b1;
    end
    check("abort ready_never", {31'd0, flag}, 32'd0);
    check("abort count", {16'd0, xact_count}, 32'd9);
    do_xact("rd_0x80_after_abort", 1'b0, 32'h80, 32'h0, 32'h0, 16'd10);

    // Hold mem_req for 5 extra cycles in RESPOND.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_address = 32'h40;
    for (int i = 0; i < 20 && !mem_ready; i++) @(negedge clk);
    check("hold data", dram_data_input, 32'hDEADBEEF);
    held = dram_data_input;
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!mem_ready || dram_data_input !== held) flag = 1'b1;
    end
    check("hold stable", {31'd0, flag}, 32'd0);
    mem_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hold ready_fall", {31'd0, mem_ready}, 32'd0);
    check("hold count", {16'd0, xact_count}, 32'd11);

    // Asynchronous reset during BUSY of a write to 0x10.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_address = 32'h10; write_data_int = 32'h55AA55AA;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset ready", {31'd0, mem_ready}, 32'd0);
    check("midreset count", {16'd0, xact_count}, 32'd0);
    check("midreset data", dram_data_input, 32'd0);
    @(negedge clk);
    mem_req = 1'b0;
    rst = 1'b1;
    do_xact("rd_0x10_after_reset", 1'b0, 32'h10, 32'h0, 32'h0, 16'd1);
    // The word at 0x40 still holds data, but its written bit was cleared.
    do_xact("rd_0x40_after_reset", 1'b0, 32'h40, 32'h0, 32'h0, 16'd2);

    // Count wraps from 0xFFFF to 0.
    @(negedge clk);
    force dut.xact_count = 16'hFFFF;
    #1 release dut.xact_count;
    #1 check("forced count", {16'd0, xact_count}, 32'h0000FFFF);
    do_xact("wrap_xact", 1'b1, 32'h20, 32'h01020304, 32'h01020304, 16'd0);

    // Latency-1 build with a non-zero def_word.
    lat1_xact("l1_rd_unwritten", 1'b0, 32'h0C, 32'h0,        32'h0BAD0BAD, 16'd1);
    lat1_xact("l1_wr_0x8",       1'b1, 32'h08, 32'h11112222, 32'h11112222, 16'd2);
    lat1_xact("l1_rd_alias",     1'b0, 32'h48, 32'h0,        32'h11112222, 16'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
